// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and constants for the countdown timer.
//   state_t  - IDLE, RUN, PAUSE, EXPIRED
//   SEC_MAX  - largest legal seconds value
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/bin2bcd2.sv
// bin2bcd2: converts a 7-bit binary value (0..99) into two BCD digits.
//   bin_i  [6:0] binary input, expected range 0..99
//   tens_o [3:0] value / 10
//   ones_o [3:0] value mod 10
module bin2bcd2 (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    assign tens_o = 4'(bin_i / 7'd10);
    assign ones_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown timer with load, add-minute, start and pause.
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   load/load_min/load_sec  preset the value (clamped), return to IDLE
//   add_min          add one minute (saturating); restarts from 01:00 when EXPIRED
//   start / pause    resume / suspend the countdown
//   min_sec  [15:0]  BCD mm:ss
//   running/expired  state decodes; done is a one-cycle pulse on reaching 00:00
module countdown_timer
    import clock_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned MAX_MIN = 99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [6:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic        add_min,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] min_sec,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam logic [23:0] DIV_LAST = 24'(CLK_DIV - 1);
    localparam logic [6:0]  MIN_CAP  = 7'(MAX_MIN);
    localparam logic [5:0]  SEC_CAP  = 6'(SEC_MAX);

    state_t      state_q, state_d;
    logic [6:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [23:0] pre_q, pre_d;
    logic        done_q, done_d;
    logic        tick;
    logic        nonzero;

    assign tick    = (state_q == RUN) && (pre_q == DIV_LAST);
    assign nonzero = (min_q != 7'd0) || (sec_q != 6'd0);

    // Commands form a strict priority chain; a tick only acts when no
    // command is present, but the prescaler keeps wrapping regardless.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pre_d   = (state_q == RUN) ? (tick ? 24'd0 : pre_q + 24'd1) : 24'd0;
        done_d  = 1'b0;
        if (load) begin
            min_d   = (load_min > MIN_CAP) ? MIN_CAP : load_min;
            sec_d   = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
            state_d = IDLE;
            pre_d   = 24'd0;
        end else if (add_min) begin
            if (state_q == EXPIRED) begin
                min_d   = 7'd1;
                sec_d   = 6'd0;
                state_d = IDLE;
            end else begin
                min_d = (min_q >= MIN_CAP) ? MIN_CAP : min_q + 7'd1;
            end
        end else if (start) begin
            if ((state_q == IDLE || state_q == PAUSE) && nonzero) begin
                state_d = RUN;
                pre_d   = 24'd0;
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
                pre_d   = 24'd0;
            end
        end else if (tick) begin
            if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
            end else begin
                min_d = min_q - 7'd1;
                sec_d = SEC_CAP;
            end
            if (min_d == 7'd0 && sec_d == 6'd0) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= 7'd0;
            sec_q   <= 6'd0;
            pre_q   <= 24'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    bin2bcd2 u_min_bcd (
        .bin_i  (min_q),
        .tens_o (min_sec[15:12]),
        .ones_o (min_sec[11:8])
    );

    bin2bcd2 u_sec_bcd (
        .bin_i  ({1'b0, sec_q}),
        .tens_o (min_sec[7:4]),
        .ones_o (min_sec[3:0])
    );

    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vector table plus multi-cycle sequences for countdown_timer.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  load_min = 7'd0;
    logic [5:0]  load_sec = 6'd0;
    logic        add_min = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] ms1, ms4;
    logic        run1, run4, exp1, exp4, done1, done4;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    countdown_timer #(.CLK_DIV(1), .MAX_MIN(99)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min), .load_sec(load_sec),
        .add_min(add_min), .start(start), .pause(pause),
        .min_sec(ms1), .running(run1), .expired(exp1), .done(done1)
    );

    countdown_timer #(.CLK_DIV(4), .MAX_MIN(99)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_min(load_min), .load_sec(load_sec),
        .add_min(add_min), .start(start), .pause(pause),
        .min_sec(ms4), .running(run4), .expired(exp4), .done(done4)
    );

    typedef struct {
        logic        ld;
        logic [6:0]  lm;
        logic [5:0]  ls;
        logic        am;
        logic        st;
        logic        pa;
        logic [15:0] ms;
        logic        r;
        logic        e;
        logic        d;
    } vec_t;

    vec_t v[28];

    function automatic vec_t mk(input logic ld, input logic [6:0] lm, input logic [5:0] ls,
                                input logic am, input logic st, input logic pa,
                                input logic [15:0] ms, input logic r, input logic e, input logic d);
        vec_t x;
        x.ld = ld; x.lm = lm; x.ls = ls; x.am = am; x.st = st; x.pa = pa;
        x.ms = ms; x.r = r; x.e = e; x.d = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, sample 1ns after the edge, then return inputs to idle.
    task automatic step(input logic ld, input logic [6:0] lm, input logic [5:0] ls,
                        input logic am, input logic st, input logic pa);
        load = ld; load_min = lm; load_sec = ls; add_min = am; start = st; pause = pa;
        @(posedge clk);
        #1;
        load = 1'b0; load_min = 7'd0; load_sec = 6'd0; add_min = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        v[0]  = mk(1, 7'd0,   6'd3,  0, 0, 0, 16'h0003, 0, 0, 0);
        v[1]  = mk(0, 7'd0,   6'd0,  0, 1, 0, 16'h0003, 1, 0, 0);
        v[2]  = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0002, 1, 0, 0);
        v[3]  = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0001, 1, 0, 0);
        v[4]  = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0000, 0, 1, 1);
        v[5]  = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0000, 0, 1, 0);
        v[6]  = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0000, 0, 1, 0);
        v[7]  = mk(0, 7'd0,   6'd0,  0, 1, 0, 16'h0000, 0, 1, 0);
        v[8]  = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h0100, 0, 0, 0);
        v[9]  = mk(1, 7'd2,   6'd0,  0, 0, 0, 16'h0200, 0, 0, 0);
        v[10] = mk(0, 7'd0,   6'd0,  0, 1, 0, 16'h0200, 1, 0, 0);
        v[11] = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0159, 1, 0, 0);
        v[12] = mk(0, 7'd0,   6'd0,  0, 0, 1, 16'h0159, 0, 0, 0);
        v[13] = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0159, 0, 0, 0);
        v[14] = mk(1, 7'd99,  6'd59, 0, 0, 0, 16'h9959, 0, 0, 0);
        v[15] = mk(1, 7'd98,  6'd0,  0, 0, 0, 16'h9800, 0, 0, 0);
        v[16] = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h9900, 0, 0, 0);
        v[17] = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h9900, 0, 0, 0);
        v[18] = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h9900, 0, 0, 0);
        v[19] = mk(1, 7'd120, 6'd63, 0, 0, 0, 16'h9959, 0, 0, 0);
        v[20] = mk(1, 7'd0,   6'd0,  0, 0, 0, 16'h0000, 0, 0, 0);
        v[21] = mk(0, 7'd0,   6'd0,  0, 1, 0, 16'h0000, 0, 0, 0);
        v[22] = mk(1, 7'd5,   6'd7,  0, 1, 1, 16'h0507, 0, 0, 0);
        v[23] = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h0607, 0, 0, 0);
        v[24] = mk(0, 7'd0,   6'd0,  0, 1, 0, 16'h0607, 1, 0, 0);
        v[25] = mk(0, 7'd0,   6'd0,  1, 0, 0, 16'h0707, 1, 0, 0);
        v[26] = mk(0, 7'd0,   6'd0,  0, 0, 0, 16'h0706, 1, 0, 0);
        v[27] = mk(1, 7'd0,   6'd59, 0, 0, 0, 16'h0059, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_min_sec", ms1, 16'h0000);
        chk("reset_running", run1, 1'b0);
        chk("reset_expired", exp1, 1'b0);
        chk("reset_done", done1, 1'b0);
        chk("reset_min_sec_div4", ms4, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(v[i].ld, v[i].lm, v[i].ls, v[i].am, v[i].st, v[i].pa);
            chk($sformatf("vec%0d_min_sec", i), ms1, v[i].ms);
            chk($sformatf("vec%0d_running", i), run1, v[i].r);
            chk($sformatf("vec%0d_expired", i), exp1, v[i].e);
            chk($sformatf("vec%0d_done", i), done1, v[i].d);
        end

        // Prescaled countdown, pause freezes, resume decrements four edges later.
        step(1, 7'd0, 6'd10, 0, 0, 0);
        step(0, 7'd0, 6'd0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 7'd0, 6'd0, 0, 0, 0);
        chk("div4_after9_min_sec", ms4, 16'h0008);
        chk("div4_after9_running", run4, 1'b1);
        step(0, 7'd0, 6'd0, 0, 0, 1);
        chk("div4_pause_min_sec", ms4, 16'h0008);
        chk("div4_pause_running", run4, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 7'd0, 6'd0, 0, 0, 0);
        chk("div4_frozen_min_sec", ms4, 16'h0008);
        step(0, 7'd0, 6'd0, 0, 1, 0);
        chk("div4_resume_running", run4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 7'd0, 6'd0, 0, 0, 0);
            chk($sformatf("div4_resume_wait%0d", i), ms4, 16'h0008);
        end
        step(0, 7'd0, 6'd0, 0, 0, 0);
        chk("div4_resume_tick", ms4, 16'h0007);

        // Asynchronous reset mid-countdown.
        step(1, 7'd5, 6'd30, 0, 0, 0);
        step(0, 7'd0, 6'd0, 0, 1, 0);
        step(0, 7'd0, 6'd0, 0, 0, 0);
        step(0, 7'd0, 6'd0, 0, 0, 0);
        chk("arst_pre_min_sec", ms4, 16'h0530);
        chk("arst_pre_running", run4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_min_sec", ms4, 16'h0000);
        chk("arst_running", run4, 1'b0);
        chk("arst_expired", exp4, 1'b0);
        chk("arst_done", done4, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 7'd0, 6'd0, 0, 0, 0);
            chk($sformatf("arst_after%0d_min_sec", i), ms4, 16'h0000);
            chk($sformatf("arst_after%0d_running", i), run4, 1'b0);
            chk($sformatf("arst_after%0d_done", i), done4, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
